// File: rtl/perm_scatter_pipe.sv
// ---------------------------------------------------------------------------
// perm_scatter_pipe
//
// Scatters LANES lanes of DW bits to the destinations named by a per-lane
// 4-bit key. The output beat is the form the inverse permutator accepts, so
// running the inverse with the same key restores the original lane order.
// The datapath is a two-stage registered pipeline with valid/ready
// handshakes on both sides:
//   S1 : registers data/key/ctrl and decodes each key to a one-hot vector
//   S2 : merges lanes (lowest source index wins, unhit lanes are zero) and
//        holds the output beat until downstream takes it
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   t_dat_dat  input lanes, lane n = bits [DW*n +: DW]
//   t_kp_dat   bits [4n+3:4n] = destination of input lane n, top CW bits = ctrl
//   t_valid    input beat valid
//   t_ready    block can accept a beat this cycle
//   i_dat_dat  scattered lanes, output lane d = bits [DW*d +: DW]
//   i_ctrl     ctrl nibble of the beat on the output
//   i_valid    output beat valid
//   i_ready    downstream accepts the beat
//   i_err      key of the output beat is not a permutation
//
// Build option:
//   KEY_CHECK_EN  when defined, S1 flags keys that are not a permutation and
//                 the flag travels with the beat onto i_err; otherwise i_err
//                 is constant 0 and no key-check logic exists.
// ---------------------------------------------------------------------------
module perm_scatter_pipe #(
   parameter int LANES = 16,
   parameter int DW    = 32,
   parameter int CW    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [LANES*DW-1:0]     t_dat_dat,
   input  logic [4*LANES+CW-1:0]   t_kp_dat,
   input  logic                    t_valid,
   output logic                    t_ready,
   output logic [LANES*DW-1:0]     i_dat_dat,
   output logic [CW-1:0]           i_ctrl,
   output logic                    i_valid,
   input  logic                    i_ready,
   output logic                    i_err
);

   localparam int KW = 4;

   // Row n of the flattened hit matrix is the one-hot destination of source n.
   function automatic logic [LANES*LANES-1:0] decode_keys(input logic [LANES*KW-1:0] keys);
      logic [LANES*LANES-1:0] h;
      h = '0;
      for (int n = 0; n < LANES; n++) begin
         h[n*LANES + int'(keys[n*KW +: KW])] = 1'b1;
      end
      return h;
   endfunction

   // Walking sources from high to low lets the lowest hitting index win.
   function automatic logic [LANES*DW-1:0] merge_lanes(input logic [LANES*DW-1:0]    dat,
                                                       input logic [LANES*LANES-1:0] h);
      logic [LANES*DW-1:0] m;
      m = '0;
      for (int d = 0; d < LANES; d++) begin
         for (int n = LANES - 1; n >= 0; n--) begin
            if (h[n*LANES + d]) m[d*DW +: DW] = dat[n*DW +: DW];
         end
      end
      return m;
   endfunction

`ifdef KEY_CHECK_EN
   // With as many sources as destinations, some destination has two hits
   // exactly when another has none, so full coverage means a permutation.
   function automatic logic key_not_perm(input logic [LANES*LANES-1:0] h);
      logic [LANES-1:0] covered;
      covered = '0;
      for (int n = 0; n < LANES; n++) begin
         covered = covered | h[n*LANES +: LANES];
      end
      return covered != {LANES{1'b1}};
   endfunction
`endif

   logic                   s1_vld_q, s1_vld_d;
   logic [LANES*DW-1:0]    s1_dat_q, s1_dat_d;
   logic [LANES*KW-1:0]    s1_key_q, s1_key_d;
   logic [CW-1:0]          s1_ctrl_q, s1_ctrl_d;

   logic                   s2_vld_q, s2_vld_d;
   logic [LANES*DW-1:0]    s2_dat_q, s2_dat_d;
   logic [CW-1:0]          s2_ctrl_q, s2_ctrl_d;
   logic                   s2_err_q, s2_err_d;

   logic [LANES*LANES-1:0] hit_s1;
   logic [LANES*DW-1:0]    merged_s1;
   logic                   err_s1;
   logic                   s2_load;
   logic                   in_xfer;

   always_comb begin
      s2_load = !s2_vld_q || i_ready;
      t_ready = !s1_vld_q || s2_load;
      in_xfer = t_valid && t_ready;

      // ---- S1: decode of the registered key ----
      hit_s1    = decode_keys(s1_key_q);
      merged_s1 = merge_lanes(s1_dat_q, hit_s1);
`ifdef KEY_CHECK_EN
      err_s1    = key_not_perm(hit_s1);
`else
      err_s1    = 1'b0;
`endif

      s1_vld_d  = s1_vld_q;
      s1_dat_d  = s1_dat_q;
      s1_key_d  = s1_key_q;
      s1_ctrl_d = s1_ctrl_q;
      if (in_xfer) begin
         s1_vld_d  = 1'b1;
         s1_dat_d  = t_dat_dat;
         s1_key_d  = t_kp_dat[LANES*KW-1:0];
         s1_ctrl_d = t_kp_dat[LANES*KW +: CW];
      end else if (s2_load) begin
         s1_vld_d  = 1'b0;
      end

      // ---- S2: merged beat into the output register ----
      s2_vld_d  = s2_vld_q;
      s2_dat_d  = s2_dat_q;
      s2_ctrl_d = s2_ctrl_q;
      s2_err_d  = s2_err_q;
      if (s2_load) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_dat_d  = merged_s1;
            s2_ctrl_d = s1_ctrl_q;
            s2_err_d  = err_s1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         s2_dat_q  <= '0;
         s2_ctrl_q <= '0;
         s2_err_q  <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s2_vld_q  <= s2_vld_d;
         s2_dat_q  <= s2_dat_d;
         s2_ctrl_q <= s2_ctrl_d;
         s2_err_q  <= s2_err_d;
      end
   end

   // S1 payload needs no reset: it is only consumed while s1_vld_q is set.
   always_ff @(posedge clk) begin
      s1_dat_q  <= s1_dat_d;
      s1_key_q  <= s1_key_d;
      s1_ctrl_q <= s1_ctrl_d;
   end

   assign i_valid   = s2_vld_q;
   assign i_dat_dat = s2_dat_q;
   assign i_ctrl    = s2_ctrl_q;
   assign i_err     = s2_err_q;

endmodule

// File: tb/tb_perm_scatter_pipe.sv
// ---------------------------------------------------------------------------
// tb_perm_scatter_pipe
//
// Bench for perm_scatter_pipe. Accepted input beats are turned into expected
// output beats by a lane-level scatter model and queued; a monitor on the
// falling edge compares every output transfer against the queue and checks
// that a stalled output beat holds. Directed sequences pin the model with
// literal values; a long randomized run covers handshakes.
// ---------------------------------------------------------------------------
module tb_perm_scatter_pipe;

   logic         clk;
   logic         reset;
   logic [511:0] t_dat_dat;
   logic [67:0]  t_kp_dat;
   logic         t_valid;
   logic         t_ready;
   logic [511:0] i_dat_dat;
   logic [3:0]   i_ctrl;
   logic         i_valid;
   logic         i_ready;
   logic         i_err;

   perm_scatter_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .t_dat_dat (t_dat_dat),
      .t_kp_dat  (t_kp_dat),
      .t_valid   (t_valid),
      .t_ready   (t_ready),
      .i_dat_dat (i_dat_dat),
      .i_ctrl    (i_ctrl),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .i_err     (i_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [511:0] dat;
      logic [3:0]   ctrl;
      logic         err;
      int           cyc;
   } exp_t;

   exp_t         q[$];
   int           tests = 0;
   int           fails = 0;
   int           cyc_n = 0;
   logic         lat_mode = 1'b0;
   logic         hold = 1'b0;
   logic [511:0] hold_dat;
   logic [3:0]   hold_ctrl;
   logic         hold_err;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Scatter model: each destination takes the first source (lowest index)
   // whose key names it, zero if none; the key is bad unless every
   // destination is named exactly once.
   function automatic exp_t model(input logic [511:0] dat, input logic [67:0] kp, input int c);
      exp_t e;
      int   cnt;
      e.dat  = '0;
      e.err  = 1'b0;
      e.ctrl = kp[67:64];
      e.cyc  = c;
      for (int d = 0; d < 16; d++) begin
         cnt = 0;
         for (int n = 0; n < 16; n++) begin
            if (kp[4*n +: 4] == 4'(d)) begin
               if (cnt == 0) e.dat[32*d +: 32] = dat[32*n +: 32];
               cnt++;
            end
         end
`ifdef KEY_CHECK_EN
         if (cnt != 1) e.err = 1'b1;
`endif
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      cyc_n++;
      if (reset) begin
         q.delete();
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_valid", {511'd0, i_valid}, 512'd1);
            chk("hold_dat", i_dat_dat, hold_dat);
            chk("hold_ctrl", {508'd0, i_ctrl}, {508'd0, hold_ctrl});
            chk("hold_err", {511'd0, i_err}, {511'd0, hold_err});
         end
         if (t_valid && t_ready) q.push_back(model(t_dat_dat, t_kp_dat, cyc_n));
         if (i_valid && i_ready) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got beat %0h, expected no beat", i_dat_dat);
            end else begin
               e = q.pop_front();
               chk("out_dat", i_dat_dat, e.dat);
               chk("out_ctrl", {508'd0, i_ctrl}, {508'd0, e.ctrl});
               chk("out_err", {511'd0, i_err}, {511'd0, e.err});
               if (lat_mode) chk("latency", 512'(cyc_n - e.cyc), 512'd2);
            end
         end
         hold      = i_valid && !i_ready;
         hold_dat  = i_dat_dat;
         hold_ctrl = i_ctrl;
         hold_err  = i_err;
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [67:0] pack_key(input int key[16], input logic [3:0] ctrl);
      logic [67:0] kp;
      for (int n = 0; n < 16; n++) kp[4*n +: 4] = 4'(key[n]);
      kp[67:64] = ctrl;
      return kp;
   endfunction

   function automatic logic [67:0] rand_perm_key(input logic [3:0] ctrl);
      int key[16];
      int j, t;
      for (int n = 0; n < 16; n++) key[n] = n;
      for (int n = 15; n > 0; n--) begin
         j = int'($urandom_range(0, n));
         t = key[n];
         key[n] = key[j];
         key[j] = t;
      end
      return pack_key(key, ctrl);
   endfunction

   function automatic logic [511:0] rand_dat();
      logic [511:0] d;
      for (int n = 0; n < 16; n++) d[32*n +: 32] = $urandom;
      return d;
   endfunction

   // Present one beat and hold it until accepted, bounded.
   task automatic send(input logic [511:0] d, input logic [67:0] kp);
      bit done = 0;
      t_valid   = 1'b1;
      t_dat_dat = d;
      t_kp_dat  = kp;
      for (int k = 0; k < 200 && !done; k++) begin
         #1;
         done = t_ready;
         @(posedge clk);
         #1;
      end
      t_valid = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got t_ready=0 for 200 cycles, expected acceptance");
      end
   endtask

   task automatic drain;
      i_ready = 1'b1;
      t_valid = 1'b0;
      for (int k = 0; k < 50 && (q.size() != 0 || i_valid); k++) cyc();
      tests++;
      if (q.size() != 0 || i_valid) begin
         fails++;
         $display("FAIL drain: got %0d beats outstanding, expected 0", q.size());
      end
   endtask

   initial begin
      int           key[16];
      logic [511:0] d;
      logic [511:0] drev;
      logic [67:0]  kp;
      logic         have;
      int           sent;
      int           guard;

      reset     = 1'b1;
      t_valid   = 1'b0;
      t_dat_dat = '0;
      t_kp_dat  = '0;
      i_ready   = 1'b1;
      repeat (3) cyc();
      reset = 1'b0;
      #1;
      chk("rst_i_valid", {511'd0, i_valid}, 512'd0);
      chk("rst_i_dat", i_dat_dat, 512'd0);
      chk("rst_i_ctrl", {508'd0, i_ctrl}, 512'd0);
      chk("rst_i_err", {511'd0, i_err}, 512'd0);
      chk("rst_t_ready", {511'd0, t_ready}, 512'd1);

      // Identity key: output equals input, after exactly two cycles.
      lat_mode = 1'b1;
      for (int n = 0; n < 16; n++) begin
         key[n] = n;
         d[32*n +: 32] = 32'hA000_0000 + 32'(n);
      end
      t_valid   = 1'b1;
      t_dat_dat = d;
      t_kp_dat  = pack_key(key, 4'h5);
      chk("id_t_ready", {511'd0, t_ready}, 512'd1);
      cyc();
      t_valid = 1'b0;
      chk("id_not_yet", {511'd0, i_valid}, 512'd0);
      cyc();
      chk("id_valid", {511'd0, i_valid}, 512'd1);
      chk("id_dat", i_dat_dat, d);
      chk("id_ctrl", {508'd0, i_ctrl}, 512'd5);
      chk("id_err", {511'd0, i_err}, 512'd0);
      drain();

      // Reversal key, 16 back-to-back beats.
      for (int n = 0; n < 16; n++) key[n] = 15 - n;
      for (int b = 0; b < 16; b++) begin
         d = rand_dat();
         if (b == 0) begin
            for (int n = 0; n < 16; n++) drev[32*(15-n) +: 32] = d[32*n +: 32];
         end
         send(d, pack_key(key, 4'(b)));
         if (b == 1) chk("rev_first", i_dat_dat, drev);
      end
      drain();

      // Collision: sources 3 and 9 both to 0, nothing to 7.
      for (int n = 0; n < 16; n++) begin
         key[n] = n;
         d[32*n +: 32] = 32'hC000_0000 + 32'(n);
      end
      key[0] = 3;
      key[3] = 0;
      key[7] = 9;
      key[9] = 0;
      send(d, pack_key(key, 4'hA));
      cyc();
      chk("col_valid", {511'd0, i_valid}, 512'd1);
      chk("col_lane0", {480'd0, i_dat_dat[31:0]}, {480'd0, 32'hC000_0003});
      chk("col_lane7", {480'd0, i_dat_dat[32*7 +: 32]}, 512'd0);
      chk("col_lane3", {480'd0, i_dat_dat[32*3 +: 32]}, {480'd0, 32'hC000_0000});
      chk("col_lane9", {480'd0, i_dat_dat[32*9 +: 32]}, {480'd0, 32'hC000_0007});
`ifdef KEY_CHECK_EN
      chk("col_err", {511'd0, i_err}, 512'd1);
`else
      chk("col_err", {511'd0, i_err}, 512'd0);
`endif
      drain();
      lat_mode = 1'b0;

      // Backpressure: two beats fit, the third stalls.
      i_ready = 1'b0;
      send(rand_dat(), rand_perm_key(4'h1));
      send(rand_dat(), rand_perm_key(4'h2));
      t_valid   = 1'b1;
      t_dat_dat = rand_dat();
      t_kp_dat  = rand_perm_key(4'h3);
      for (int k = 0; k < 3; k++) begin
         chk("bp_t_ready", {511'd0, t_ready}, 512'd0);
         cyc();
      end
      i_ready = 1'b1;
      send(t_dat_dat, t_kp_dat);
      drain();

      // Randomized traffic with permutation keys.
      sent  = 0;
      guard = 0;
      have  = 1'b0;
      while (sent < 10000 && guard < 60000) begin
         if (!have && $urandom_range(0, 3) != 0) begin
            t_dat_dat = rand_dat();
            t_kp_dat  = rand_perm_key(4'($urandom));
            have      = 1'b1;
         end
         t_valid = have;
         i_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (have && t_ready) begin
            have = 1'b0;
            sent++;
         end
         @(posedge clk);
         #1;
         t_valid = 1'b0;
         guard++;
      end
      tests++;
      if (sent < 10000) begin
         fails++;
         $display("FAIL random_progress: got %0d beats sent, expected 10000", sent);
      end
      drain();

      // Reset with both stages full.
      i_ready = 1'b0;
      send(rand_dat(), rand_perm_key(4'h6));
      send(rand_dat(), rand_perm_key(4'h7));
      t_valid = 1'b1;
      #1;
      chk("full_i_valid", {511'd0, i_valid}, 512'd1);
      chk("full_t_ready", {511'd0, t_ready}, 512'd0);
      reset = 1'b1;
      cyc();
      reset   = 1'b0;
      t_valid = 1'b0;
      #1;
      chk("rst2_i_valid", {511'd0, i_valid}, 512'd0);
      chk("rst2_t_ready", {511'd0, t_ready}, 512'd1);
      chk("rst2_i_dat", i_dat_dat, 512'd0);
      i_ready = 1'b1;
      repeat (10) cyc();
      chk("rst2_quiet", {511'd0, i_valid}, 512'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
